// File: rtl/return_addr_stack.sv
// return_addr_stack: parametrised hardware return-address stack.
// CALL pushes the link address, RET pops; top_addr is the combinational RET target.
// Push+pop together replaces the top entry (tail call). Error flags are sticky until clr_err.
module return_addr_stack #(
   parameter int ADDR_W       = 19,
   parameter int DEPTH        = 16,
   parameter int WRAP_ON_FULL = 0,
   parameter int CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              pop,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] top_addr,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  tp_q, tp_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic [PTR_W-1:0]  tp_m1;
   logic              is_empty;
   logic              is_full;
   logic              ovf_event;
   logic              unf_event;

   assign tp_m1    = tp_q - PTR_W'(1);
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(DEPTH));

   // Next-state decode: one operation per cycle, pointer arithmetic wraps modulo DEPTH.
   always_comb begin
      mem_d     = mem_q;
      tp_d      = tp_q;
      count_d   = count_q;
      ovf_event = 1'b0;
      unf_event = 1'b0;

      if (push && pop && !is_empty) begin
         mem_d[tp_m1] = push_addr;
      end else if (push) begin
         if (pop) begin
            unf_event = 1'b1;
         end
         if (!is_full) begin
            mem_d[tp_q] = push_addr;
            tp_d        = tp_q + PTR_W'(1);
            count_d     = count_q + CNT_W'(1);
         end else begin
            ovf_event = 1'b1;
            if (WRAP_ON_FULL != 0) begin
               mem_d[tp_q] = push_addr;
               tp_d        = tp_q + PTR_W'(1);
            end
         end
      end else if (pop) begin
         if (is_empty) begin
            unf_event = 1'b1;
         end else begin
            tp_d    = tp_m1;
            count_d = count_q - CNT_W'(1);
         end
      end

      overflow_d  = (overflow_q  & ~clr_err) | ovf_event;
      underflow_d = (underflow_q & ~clr_err) | unf_event;
   end

   // State registers with synchronous reset that also clears every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q       <= '{default: '0};
         tp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         tp_q        <= tp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign top_addr  = is_empty ? '0 : mem_q[tp_m1];
   assign empty     = is_empty;
   assign full      = is_full;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed vectors against three stack configurations
// (default 16-deep, 4-deep dropping, 4-deep wrapping) sharing one stimulus bus.
module tb_return_addr_stack;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [18:0] push_addr;
   logic        pop;
   logic        clr_err;

   logic [18:0] a_top, n_top, w_top;
   logic        a_empty, n_empty, w_empty;
   logic        a_full, n_full, w_full;
   logic [4:0]  a_count;
   logic [2:0]  n_count, w_count;
   logic        a_ovf, n_ovf, w_ovf;
   logic        a_unf, n_unf, w_unf;

   int total = 0;
   int bad   = 0;

   int expN [4] = '{9, 3, 2, 1};
   int expW [4] = '{9, 5, 4, 3};

   return_addr_stack u_a (
      .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop), .clr_err(clr_err),
      .top_addr(a_top), .empty(a_empty), .full(a_full), .count(a_count),
      .overflow(a_ovf), .underflow(a_unf)
   );

   return_addr_stack #(.DEPTH(4), .WRAP_ON_FULL(0)) u_n (
      .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop), .clr_err(clr_err),
      .top_addr(n_top), .empty(n_empty), .full(n_full), .count(n_count),
      .overflow(n_ovf), .underflow(n_unf)
   );

   return_addr_stack #(.DEPTH(4), .WRAP_ON_FULL(1)) u_w (
      .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop), .clr_err(clr_err),
      .top_addr(w_top), .empty(w_empty), .full(w_full), .count(w_count),
      .overflow(w_ovf), .underflow(w_unf)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, lets the edge sample them, then returns to idle 1 unit later.
   task automatic applyStimulus(input logic ps, input logic [18:0] addr, input logic pp,
                                input logic ce, input logic r);
      push      = ps;
      push_addr = addr;
      pop       = pp;
      clr_err   = ce;
      rst       = r;
      @(posedge clk);
      #1;
      push      = 1'b0;
      push_addr = '0;
      pop       = 1'b0;
      clr_err   = 1'b0;
      rst       = 1'b0;
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      push = 1'b0; push_addr = '0; pop = 1'b0; clr_err = 1'b0; rst = 1'b0;

      // Reset state
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_top",   32'(a_top),   32'h0);
      checkOutput("rst_empty", 32'(a_empty), 32'h1);
      checkOutput("rst_full",  32'(a_full),  32'h0);
      checkOutput("rst_count", 32'(a_count), 32'h0);
      checkOutput("rst_ovf",   32'(a_ovf),   32'h0);
      checkOutput("rst_unf",   32'(a_unf),   32'h0);

      // Basic push/pop on the 16-deep stack
      applyStimulus(1'b1, 19'h00010, 1'b0, 1'b0, 1'b0);
      checkOutput("push1_top", 32'(a_top), 32'h10);
      applyStimulus(1'b1, 19'h00020, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 19'h00030, 1'b0, 1'b0, 1'b0);
      checkOutput("push3_count", 32'(a_count), 32'd3);
      checkOutput("push3_top",   32'(a_top),   32'h30);
      checkOutput("push3_empty", 32'(a_empty), 32'h0);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("pop1_top", 32'(a_top), 32'h20);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("pop2_top", 32'(a_top), 32'h10);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("pop3_top",   32'(a_top),   32'h0);
      checkOutput("pop3_empty", 32'(a_empty), 32'h1);
      checkOutput("pop3_ovf",   32'(a_ovf),   32'h0);
      checkOutput("pop3_unf",   32'(a_unf),   32'h0);

      // Full behaviour on the 4-deep stacks
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 19'(i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("n_fill_ovf", 32'(n_ovf), 32'h0);
      applyStimulus(1'b1, 19'd5, 1'b0, 1'b0, 1'b0);
      checkOutput("n_full",  32'(n_full),  32'h1);
      checkOutput("n_count", 32'(n_count), 32'd4);
      checkOutput("n_top",   32'(n_top),   32'd4);
      checkOutput("n_ovf",   32'(n_ovf),   32'h1);
      applyStimulus(1'b1, 19'd6, 1'b0, 1'b0, 1'b0);
      checkOutput("w_count", 32'(w_count), 32'd4);
      checkOutput("w_top",   32'(w_top),   32'd6);
      checkOutput("w_ovf",   32'(w_ovf),   32'h1);
      checkOutput("n_top6",  32'(n_top),   32'd4);

      // Clear overflow, then tail-call replace while full
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("n_clr_ovf", 32'(n_ovf), 32'h0);
      checkOutput("w_clr_ovf", 32'(w_ovf), 32'h0);
      applyStimulus(1'b1, 19'd9, 1'b1, 1'b0, 1'b0);
      checkOutput("n_rep_top",   32'(n_top),   32'd9);
      checkOutput("n_rep_count", 32'(n_count), 32'd4);
      checkOutput("n_rep_ovf",   32'(n_ovf),   32'h0);
      checkOutput("w_rep_top",   32'(w_top),   32'd9);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("n_drain%0d", i), 32'(n_top), 32'(expN[i]));
         checkOutput($sformatf("w_drain%0d", i), 32'(w_top), 32'(expW[i]));
         applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("n_drained_empty", 32'(n_empty), 32'h1);
      checkOutput("w_drained_empty", 32'(w_empty), 32'h1);
      checkOutput("w_drained_top",   32'(w_top),   32'h0);

      // Underflow, clear, and set-wins-over-clear
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("unf_set",   32'(a_unf),   32'h1);
      checkOutput("unf_count", 32'(a_count), 32'h0);
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("unf_clr", 32'(a_unf), 32'h0);
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("unf_idle", 32'(a_unf), 32'h0);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b1, 1'b0);
      checkOutput("unf_setwins", 32'(a_unf), 32'h1);

      // Tail-call replace, and push+pop on an empty stack
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 19'h0AAAA, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 19'h05555, 1'b1, 1'b0, 1'b0);
      checkOutput("tc_count", 32'(a_count), 32'd1);
      checkOutput("tc_top",   32'(a_top),   32'h05555);
      checkOutput("tc_unf",   32'(a_unf),   32'h0);
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 19'd7, 1'b1, 1'b0, 1'b0);
      checkOutput("tce_count", 32'(a_count), 32'd1);
      checkOutput("tce_top",   32'(a_top),   32'd7);
      checkOutput("tce_unf",   32'(a_unf),   32'h1);

      // Reset mid-sequence overrides a same-cycle push
      applyStimulus(1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 19'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 19'h22, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_count", 32'(a_count), 32'd2);
      applyStimulus(1'b1, 19'h33, 1'b0, 1'b0, 1'b1);
      checkOutput("mrst_count", 32'(a_count), 32'h0);
      checkOutput("mrst_top",   32'(a_top),   32'h0);
      checkOutput("mrst_empty", 32'(a_empty), 32'h1);
      checkOutput("mrst_unf",   32'(a_unf),   32'h0);
      checkOutput("mrst_ovf",   32'(a_ovf),   32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
